// File: rtl/cv32e40p_fault_monitor.sv
// Fault monitor for the triplicated ALU fault flags: per-line counters, windowed alarm FSM, first-fault capture.
// Optional macro CV32E40P_FAULT_MON_TIMESTAMP_EN adds a free-running cycle counter that stamps the first fault.
module cv32e40p_fault_monitor #(
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [2:0]       fault_i,
  input  logic [31:0]      addr_i,
  input  logic             clear_i,
  input  logic             alarm_ack_i,
  output logic             alarm_o,
  output logic [CNT_W-1:0] cnt1_o,
  output logic [CNT_W-1:0] cnt2_o,
  output logic [CNT_W-1:0] cnt3_o,
  output logic [2:0]       first_mask_o,
  output logic [31:0]      first_addr_o,
  output logic [31:0]      first_time_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LATCHED = 2'd2,
    ALARM   = 2'd3
  } state_e;

  localparam logic [7:0] TH = 8'(THRESHOLD);

  state_e           state;
  logic [CNT_W-1:0] cnt1, cnt2, cnt3;
  logic [7:0]       win;
  logic [7:0]       win_next;
  logic [1:0]       pop;
  logic [2:0]       first_mask;
  logic [31:0]      first_addr;
  logic             captured;
  logic             count_en;
  logic             ack_ok;
  logic             capture;
  logic             hit_th;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Counting happens only while enabled outside IDLE; an accepted ack empties the window before this cycle's faults land.
  always_comb begin
    pop      = {1'b0, fault_i[0]} + {1'b0, fault_i[1]} + {1'b0, fault_i[2]};
    count_en = enable_i && (state != IDLE);
    ack_ok   = count_en && (state == ALARM) && alarm_ack_i;
    win_next = count_en ? sat_add8(ack_ok ? 8'd0 : win, pop) : win;
    hit_th   = (win_next >= TH);
    capture  = enable_i && (state == ARMED) && (fault_i != 3'b000) && !captured;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt1       <= '0;
      cnt2       <= '0;
      cnt3       <= '0;
      win        <= '0;
      first_mask <= '0;
      first_addr <= '0;
      captured   <= 1'b0;
    end else if (clear_i) begin
      state      <= enable_i ? ARMED : IDLE;
      cnt1       <= '0;
      cnt2       <= '0;
      cnt3       <= '0;
      win        <= '0;
      first_mask <= '0;
      first_addr <= '0;
      captured   <= 1'b0;
    end else if (!enable_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    state <= ARMED;
        ARMED:   if (fault_i != 3'b000) state <= hit_th ? ALARM : LATCHED;
        LATCHED: if (hit_th) state <= ALARM;
        ALARM:   if (alarm_ack_i) state <= LATCHED;
        default: state <= IDLE;
      endcase
      if (count_en) begin
        cnt1 <= sat_inc(cnt1, fault_i[0]);
        cnt2 <= sat_inc(cnt2, fault_i[1]);
        cnt3 <= sat_inc(cnt3, fault_i[2]);
        win  <= win_next;
      end
      if (capture) begin
        first_mask <= fault_i;
        first_addr <= addr_i;
        captured   <= 1'b1;
      end
    end
  end

`ifdef CV32E40P_FAULT_MON_TIMESTAMP_EN
  logic [31:0] cycle;
  logic [31:0] first_time;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cycle <= '0;
    else
      cycle <= cycle + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i)
      first_time <= '0;
    else if (capture)
      first_time <= cycle;
  end

  assign first_time_o = first_time;
`else
  assign first_time_o = '0;
`endif

  assign alarm_o      = (state == ALARM);
  assign state_o      = state;
  assign cnt1_o       = cnt1;
  assign cnt2_o       = cnt2;
  assign cnt3_o       = cnt3;
  assign first_mask_o = first_mask;
  assign first_addr_o = first_addr;

endmodule
